sync_sram_store: RTL
====================

Name: sync_sram_store

Overview:
- Clocked, parametrised word store: the successor to the 1024x4 asynchronous SRAM part.
- Width and depth are parametrised. Default is 32 words x 32 bits, the Manchester Baby store.
- Adds a synchronous request/ready handshake, programmable wait states (models slow TTL/SRAM access) and an automatic clear sweep after reset.
- Sits between the control unit and main store. Replaces ad-hoc CS_n/WE_n sequencing with a single-clock interface.

Parameters:
- DATA_WIDTH, 32, bits per word (1..64).
- ADDR_WIDTH, 5, address bits; depth = 2**ADDR_WIDTH.
- WAIT_STATES, 0, extra busy cycles per access (0..15).
- CLEAR_ON_RESET, 1, 1 = sweep all locations to zero after reset; 0 = contents left unchanged.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- req  input  1  access request; sampled only when ready=1.
- we  input  1  1 = write, 0 = read; qualified by req.
- addr  input  ADDR_WIDTH  word address.
- wdata  input  DATA_WIDTH  write data.
- ready  output  1  store idle and able to accept req.
- rdata  output  DATA_WIDTH  read data; held until the next read completes.
- rvalid  output  1  one-cycle pulse when rdata is updated.
- clearing  output  1  high during the post-reset clear sweep.

Behaviour:
- Reset: on a rising edge with reset_n=0:
  - ready=0, rvalid=0, rdata=0.
  - clearing=CLEAR_ON_RESET; clear pointer=0; wait counter=0.
  - State = CLEAR if CLEAR_ON_RESET, else IDLE.
  - Memory array is not reset by reset_n itself.
- State CLEAR:
  - Each cycle writes zero to mem[ptr]; ptr increments.
  - After writing ptr=2**ADDR_WIDTH-1: next state IDLE, clearing=0, ready=1.
  - Sweep takes exactly 2**ADDR_WIDTH cycles.
  - req is ignored throughout.
- State IDLE:
  - ready=1.
  - On an edge with req=1, addr/we/wdata are captured.
  - Write (we=1): mem[addr] <= wdata on the same edge.
  - Then, if WAIT_STATES=0, stay in IDLE. Otherwise go to WAIT, ready=0, counter=WAIT_STATES.
- State WAIT:
  - Counter decrements each cycle; ready=0; req is ignored.
  - When the counter reaches 1, next state IDLE.
- Read timing:
  - Data is taken from the captured address.
  - rdata/rvalid update exactly WAIT_STATES+1 cycles after the accepting edge.
  - Write timing: data is visible to a read accepted on the following edge.
- Back-to-back: with WAIT_STATES=0, one access is accepted per cycle; pipelined read throughput is 1/cycle at latency 1.
- Read-after-write to the same address on consecutive accepts returns the new data.
- Reset mid-operation (mid-clear or mid-wait):
  - The pending access is abandoned; rvalid is not issued.
  - The clear sweep restarts from address 0.
  - A write already committed at its accepting edge stays committed.
- Address wrap: addr is exactly ADDR_WIDTH wide; no out-of-range condition exists.
- rvalid is never asserted for writes.

Optional Feature:
- Macro: SYNC_SRAM_PARITY_EN.
- When defined:
  - Each location stores one extra even-parity bit, computed from the written data (the clear sweep stores parity of zero).
  - Extra output parity_err (1 bit) asserts together with rvalid when the stored parity mismatches the stored data; otherwise 0.
  - parity_err resets to 0.
- When undefined: no parity storage and no parity_err port; behaviour is otherwise identical.

Test Plan:
- Reset, CLEAR_ON_RESET=1, ADDR_WIDTH=5: release reset_n -> clearing=1 and ready=0 for 32 cycles, then ready=1; a read of addr 0x1F returns 0x00000000.
- WAIT_STATES=0: write 0xDEADBEEF to 0x00, then 0x12345678 to 0x1F, then read 0x00 and 0x1F back-to-back -> rvalid on consecutive cycles with those values, latency 1.
- WAIT_STATES=3: read request accepted -> ready low 3 cycles; rvalid with data exactly 4 cycles after the accept; req held high while ready=0 produces no extra access.
- Boundary patterns at address 0x10: write 0x00000000, 0xFFFFFFFF, 0xAAAAAAAA, 0x55555555, each read back -> exact match; neighbours 0x0F and 0x11 remain 0.
- Reset mid-clear (reset_n low at sweep cycle 10 for 1 cycle) -> sweep restarts and takes a full 32 more cycles; reset during a WAIT read -> no rvalid, rdata=0.
- SYNC_SRAM_PARITY_EN: write 0x0000000F to 0x05, flip bit 0 of the stored word hierarchically, read 0x05 -> rvalid=1, parity_err=1, rdata=0x0000000E; an uncorrupted read gives parity_err=0.

Source files
------------

// File: rtl/sync_sram_store.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_sram_store: clocked word store with ready handshake, wait states and  |
// | post-reset clear sweep. Optional parity via SYNC_SRAM_PARITY_EN.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync_sram_store #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int WAIT_STATES    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
`ifdef SYNC_SRAM_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  clearing
);

  localparam int          c_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]  c_WS    = 4'(WAIT_STATES);
  localparam logic [1:0]  c_CLEAR = 2'd0;
  localparam logic [1:0]  c_IDLE  = 2'd1;
  localparam logic [1:0]  c_WAIT  = 2'd2;

  logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];

  logic [1:0]            r_state;
  logic                  r_ready;
  logic                  r_clearing;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rd;
  logic                  r_fire;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;

  logic                  w_accept;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_din;

  assign w_accept   = r_ready && req && (r_state == c_IDLE);
  assign w_mem_we   = reset_n && ((r_state == c_CLEAR) || (w_accept && we));
  assign w_mem_addr = (r_state == c_CLEAR) ? r_ptr : addr;
  assign w_mem_din  = (r_state == c_CLEAR) ? '0 : wdata;

  // Array has no reset: only the sweep or an accepted write changes it.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? c_CLEAR : c_IDLE;
      r_ready    <= 1'b0;
      r_clearing <= (CLEAR_ON_RESET != 0);
      r_ptr      <= '0;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_rd       <= 1'b0;
      r_fire     <= 1'b0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      // r_fire marks the edge on which the captured read lands in rdata.
      r_fire   <= 1'b0;
      r_rvalid <= r_fire;
      if (r_fire) r_rdata <= r_mem[r_addr];
      case (r_state)
        c_CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == '1) begin
            r_state    <= c_IDLE;
            r_clearing <= 1'b0;
            r_ready    <= 1'b1;
          end
        end
        c_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_addr <= addr;
            r_rd   <= ~we;
            if (c_WS == 4'd0) begin
              r_fire <= ~we;
            end else begin
              r_state <= c_WAIT;
              r_ready <= 1'b0;
              r_cnt   <= c_WS;
            end
          end
        end
        c_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= c_IDLE;
            r_ready <= 1'b1;
            r_fire  <= r_rd;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

`ifdef SYNC_SRAM_PARITY_EN
  logic r_par [0:c_DEPTH-1];
  logic r_perr;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_par[w_mem_addr] <= ^w_mem_din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_perr <= 1'b0;
    else          r_perr <= r_fire && (r_par[r_addr] != ^r_mem[r_addr]);
  end

  assign parity_err = r_perr;
`endif

  assign ready    = r_ready;
  assign rdata    = r_rdata;
  assign rvalid   = r_rvalid;
  assign clearing = r_clearing;

endmodule
`default_nettype wire
